// File: rtl/life_pkg.sv
// rtl/life_pkg.sv - shared types, grid defaults and the B3/S23 cell rule
package life_pkg;

    localparam int COLS_DEFAULT = 80;
    localparam int ROWS_DEFAULT = 60;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        FIN
    } state_t;

    // Birth on exactly three neighbours, survival on two or three
    function automatic logic life_rule(input logic alive, input logic [3:0] n);
        return (n == 4'd3) || (alive && (n == 4'd2));
    endfunction

endpackage

// File: rtl/life_row_rule.sv
// rtl/life_row_rule.sv - combinational next-row computation from a 3-row window
module life_row_rule
    import life_pkg::*;
#(
    parameter int COLS = COLS_DEFAULT,
    parameter bit WRAP = 1'b1
) (
    input  logic [COLS-1:0] top,
    input  logic [COLS-1:0] mid,
    input  logic [COLS-1:0] bot,
    output logic [COLS-1:0] next_row
);

    // Bit 0 holds column -1 and bit COLS+1 holds column COLS, so cell c sits at bit c+1
    logic [COLS+1:0] top_p;
    logic [COLS+1:0] mid_p;
    logic [COLS+1:0] bot_p;

    assign top_p = {(WRAP ? top[0] : 1'b0), top, (WRAP ? top[COLS-1] : 1'b0)};
    assign mid_p = {(WRAP ? mid[0] : 1'b0), mid, (WRAP ? mid[COLS-1] : 1'b0)};
    assign bot_p = {(WRAP ? bot[0] : 1'b0), bot, (WRAP ? bot[COLS-1] : 1'b0)};

    // Count the eight neighbours of every cell and apply the rule
    always_comb begin
        next_row = '0;
        for (int c = 0; c < COLS; c++) begin
            next_row[c] = life_rule(mid_p[c+1],
                4'(top_p[c]) + 4'(top_p[c+1]) + 4'(top_p[c+2]) +
                4'(mid_p[c])                  + 4'(mid_p[c+2]) +
                4'(bot_p[c]) + 4'(bot_p[c+1]) + 4'(bot_p[c+2]));
        end
    end

endmodule

// File: rtl/life_generation_engine.sv
// rtl/life_generation_engine.sv - streams one grid generation through a sliding row window
module life_generation_engine
    import life_pkg::*;
#(
    parameter int COLS   = COLS_DEFAULT,
    parameter int ROWS   = ROWS_DEFAULT,
    parameter bit WRAP   = 1'b1,
    parameter int ADDR_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              rdEn,
    output logic [ADDR_W-1:0] rdAddr,
    input  logic [COLS-1:0]   rdData,
    output logic              wrEn,
    output logic [ADDR_W-1:0] wrAddr,
    output logic [COLS-1:0]   wrData,
    output logic              busy,
    output logic              done,
    output logic [15:0]       genCount
);

    localparam int                IDX_W    = $clog2(ROWS + 2);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(ROWS + 1);
    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(ROWS - 1);

    state_t           state;
    logic [IDX_W-1:0] rd_idx;
    logic             launch;
    logic             data_valid;
    logic             data_zero;
    logic [1:0]       fill_cnt;
    logic [COLS-1:0]  win_top;
    logic [COLS-1:0]  win_mid;
    logic [COLS-1:0]  win_bot;
    logic [COLS-1:0]  next_row;

    assign launch = (state == IDLE) && start;

    // Sequencer: issues the wrapped read order, then closes out the generation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rdEn     <= 1'b0;
            rdAddr   <= '0;
            rd_idx   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            genCount <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= RUN;
                        rdEn   <= 1'b1;
                        rdAddr <= LAST_ROW;
                        rd_idx <= '0;
                        busy   <= 1'b1;
                    end
                end
                RUN: begin
                    if (rd_idx == LAST_IDX) begin
                        state  <= DRAIN;
                        rdEn   <= 1'b0;
                        rdAddr <= '0;
                    end else begin
                        rd_idx <= rd_idx + 1'b1;
                        rdAddr <= ((rd_idx == '0) || (rdAddr == LAST_ROW)) ? '0 : rdAddr + 1'b1;
                    end
                end
                DRAIN: begin
                    // Last write is the one with no further datum behind it
                    if (wrEn && !data_valid) begin
                        state    <= FIN;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        genCount <= genCount + 16'd1;
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Data side: shift returning rows into the window and schedule one write per full window
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_valid <= 1'b0;
            data_zero  <= 1'b0;
            fill_cnt   <= '0;
            win_top    <= '0;
            win_mid    <= '0;
            win_bot    <= '0;
            wrEn       <= 1'b0;
            wrAddr     <= '0;
        end else begin
            data_valid <= rdEn;
            // Without wrap the halo rows above row 0 and below the last row are dead
            data_zero  <= rdEn && !WRAP && ((rd_idx == '0) || (rd_idx == LAST_IDX));
            wrEn       <= data_valid && (fill_cnt == 2'd2);
            if (launch) begin
                fill_cnt <= '0;
                wrAddr   <= '0;
            end else if (wrEn) begin
                wrAddr <= (wrAddr == LAST_ROW) ? '0 : wrAddr + 1'b1;
            end
            if (data_valid) begin
                win_top <= win_mid;
                win_mid <= win_bot;
                win_bot <= data_zero ? '0 : rdData;
                if (fill_cnt != 2'd2) begin
                    fill_cnt <= fill_cnt + 2'd1;
                end
            end
        end
    end

    life_row_rule #(
        .COLS(COLS),
        .WRAP(WRAP)
    ) u_rule (
        .top     (win_top),
        .mid     (win_mid),
        .bot     (win_bot),
        .next_row(next_row)
    );

    assign wrData = wrEn ? next_row : '0;

endmodule

// File: tb/tb_life_generation_engine.sv
// tb/tb_life_generation_engine.sv - self-checking bench for life_generation_engine
module tb_life_generation_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [3:0]  start_v;
    wire         rd_en_a   [4];
    wire  [5:0]  rd_addr_a [4];
    logic [79:0] rd_data_a [4];
    wire         wr_en_a   [4];
    wire  [5:0]  wr_addr_a [4];
    wire  [79:0] wr_data_a [4];
    wire         busy_a    [4];
    wire         done_a    [4];
    wire  [15:0] gc_a      [4];

    logic [79:0] cur  [4][64];
    logic [79:0] nxt  [4][64];
    logic [79:0] expd [4][64];
    logic [15:0] gc_exp [4];
    int checks = 0;
    int errors = 0;

    // Engines 0/1: 8x6 wrap/no-wrap, engines 2/3: 80x60 wrap/no-wrap
    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int C  = (g < 2) ? 8 : 80;
        localparam int R  = (g < 2) ? 6 : 60;
        localparam bit WP = ((g % 2) == 0);
        localparam int A  = $clog2(R);
        wire [A-1:0] ra;
        wire [A-1:0] wa;
        wire [C-1:0] wd;
        life_generation_engine #(.COLS(C), .ROWS(R), .WRAP(WP)) u_dut (
            .clk(clk), .rst(rst), .start(start_v[g]),
            .rdEn(rd_en_a[g]), .rdAddr(ra), .rdData(rd_data_a[g][C-1:0]),
            .wrEn(wr_en_a[g]), .wrAddr(wa), .wrData(wd),
            .busy(busy_a[g]), .done(done_a[g]), .genCount(gc_a[g])
        );
        assign rd_addr_a[g] = 6'(ra);
        assign wr_addr_a[g] = 6'(wa);
        assign wr_data_a[g] = 80'(wd);
    end

    // One-cycle synchronous read from each engine's current-generation buffer
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rd_en_a[i]) rd_data_a[i] <= cur[i][rd_addr_a[i]];
        end
    end

    function automatic int ncols(input int i); return (i < 2) ? 8 : 80; endfunction
    function automatic int nrows(input int i); return (i < 2) ? 6 : 60; endfunction
    function automatic bit wrap_of(input int i); return (i % 2) == 0; endfunction

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference: count live neighbours of every cell directly on the grid
    task automatic model(input int i);
        int R, C, n, rr, cc;
        R = nrows(i);
        C = ncols(i);
        for (int r = 0; r < 64; r++) expd[i][r] = '0;
        for (int r = 0; r < R; r++) begin
            for (int c = 0; c < C; c++) begin
                n = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if (dr != 0 || dc != 0) begin
                            rr = r + dr;
                            cc = c + dc;
                            if (wrap_of(i)) begin
                                rr = (rr + R) % R;
                                cc = (cc + C) % C;
                            end
                            if (rr >= 0 && rr < R && cc >= 0 && cc < C && cur[i][rr][cc])
                                n++;
                        end
                    end
                end
                expd[i][r][c] = (n == 3) || (cur[i][r][c] && n == 2);
            end
        end
    endtask

    task automatic clear_grid(input int i);
        for (int r = 0; r < 64; r++) cur[i][r] = '0;
    endtask

    task automatic random_grid(input int i);
        logic [95:0] t;
        for (int r = 0; r < 64; r++) begin
            t = {$urandom, $urandom, $urandom};
            cur[i][r] = (r < nrows(i)) ? t[79:0] : '0;
        end
    endtask

    // One generation with cycle-exact checks; also pokes start on cycle 4 and in FIN
    task automatic run_gen(input int i);
        int R, nw;
        bit seen;
        R = nrows(i);
        nw = 0;
        seen = 1'b0;
        model(i);
        for (int r = 0; r < 64; r++) nxt[i][r] = '0;
        @(negedge clk);
        start_v[i] = 1'b1;
        @(negedge clk);
        start_v[i] = 1'b0;
        for (int k = 1; k <= R + 6; k++) begin
            check("rdEn", rd_en_a[i], (k <= R + 2));
            if (rd_en_a[i] && k <= R + 2)
                check("rdAddr", rd_addr_a[i], (k == 1) ? R - 1 : (k - 2) % R);
            check("wrEn", wr_en_a[i], (k >= 5 && k <= R + 4));
            if (wr_en_a[i]) begin
                check("wrAddr", wr_addr_a[i], k - 5);
                check("wrData", wr_data_a[i], expd[i][wr_addr_a[i]]);
                nxt[i][wr_addr_a[i]] = wr_data_a[i];
                nw++;
            end
            check("busy", busy_a[i], (k <= R + 4));
            check("done", done_a[i], (k == R + 5));
            if (done_a[i]) begin
                seen = 1'b1;
                gc_exp[i] = gc_exp[i] + 16'd1;
                check("genCount", gc_a[i], gc_exp[i]);
            end
            start_v[i] = (k == 4) || (k == R + 5);
            @(negedge clk);
        end
        start_v[i] = 1'b0;
        check("rows_written", nw, R);
        check("done_seen", seen, 1'b1);
        for (int r = 0; r < 64; r++) cur[i][r] = nxt[i][r];
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) gc_exp[i] = '0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rdEn"}, rd_en_a[0], 1'b0);
        check({tag, "_rdAddr"}, rd_addr_a[0], 6'd0);
        check({tag, "_wrEn"}, wr_en_a[0], 1'b0);
        check({tag, "_wrAddr"}, wr_addr_a[0], 6'd0);
        check({tag, "_wrData"}, wr_data_a[0], 80'd0);
        check({tag, "_busy"}, busy_a[0], 1'b0);
        check({tag, "_done"}, done_a[0], 1'b0);
        check({tag, "_genCount"}, gc_a[0], 16'd0);
    endtask

    initial begin
        rst = 1'b1;
        start_v = '0;
        for (int i = 0; i < 4; i++) begin
            clear_grid(i);
            gc_exp[i] = '0;
        end
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;

        // Blinker; reset lands on cycle 7 of the first attempt
        cur[0][2] = 80'h08;
        cur[0][3] = 80'h08;
        cur[0][4] = 80'h08;
        @(negedge clk);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (6) @(negedge clk);
        check("pre_reset_busy", busy_a[0], 1'b1);
        rst = 1'b1;
        #1;
        check_idle_outputs("midrun");
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            check("abandoned_done", done_a[0], 1'b0);
            @(negedge clk);
        end
        check("abandoned_genCount", gc_a[0], 16'd0);

        run_gen(0);
        for (int r = 0; r < 6; r++) check("blinker_gen1", cur[0][r], (r == 3) ? 80'h1C : 80'h0);
        run_gen(0);
        for (int r = 0; r < 6; r++) check("blinker_gen2", cur[0][r], (r >= 2 && r <= 4) ? 80'h08 : 80'h0);

        // Still life
        pulse_reset();
        clear_grid(0);
        cur[0][1] = 80'h18;
        cur[0][2] = 80'h18;
        repeat (3) run_gen(0);
        for (int r = 0; r < 6; r++) check("block", cur[0][r], (r == 1 || r == 2) ? 80'h18 : 80'h0);
        check("block_genCount", gc_a[0], 16'd3);

        // Corner cells with and without wrap
        for (int i = 0; i < 2; i++) begin
            clear_grid(i);
            cur[i][0] = 80'h81;
            cur[i][5] = 80'h01;
        end
        run_gen(0);
        check("corner_wrap_born", cur[0][5][7], 1'b1);
        run_gen(1);
        for (int r = 0; r < 6; r++) check("corner_nowrap", cur[1][r], 80'h0);

        // Random 80x60 grids, 100 generations per edge mode
        for (int i = 2; i < 4; i++) begin
            for (int g = 0; g < 100; g++) begin
                if (g % 25 == 0) random_grid(i);
                if (i == 2 && g == 99) begin
                    @(negedge clk);
                    force g_dut[2].u_dut.genCount = 16'hFFFF;
                    #1;
                    release g_dut[2].u_dut.genCount;
                    gc_exp[2] = 16'hFFFF;
                    check("preload_genCount", gc_a[2], 16'hFFFF);
                end
                run_gen(i);
            end
        end
        check("wrapped_genCount", gc_a[2], 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
